// File: rtl/veririsc_controller.sv
// VeriRISC instruction sequencer: 8-phase counter plus combinational strobe decode.
// Optional macro VERIRISC_CTRL_STEP_EN adds a 'step' input that gates phase advance.
module veririsc_controller #(
  parameter int PHASES = 8,
  parameter int OPC_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
`ifdef VERIRISC_CTRL_STEP_EN
  input  logic             step,
`endif
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             halt,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic [2:0]       phase
);

  if (PHASES != 8) begin : g_bad_phases
    $error("veririsc_controller: only PHASES=8 is supported");
  end

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  phase_t state;
  logic   halted;
  logic   advance;
  logic   alu_op;

`ifdef VERIRISC_CTRL_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase  = state;

  // HLT freezes the counter in OP_ADDR; only rst releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else if (!halted && advance) begin
      if (state == OP_ADDR && opcode == OP_HLT)
        halted <= 1'b1;
      else
        state <= phase_t'(state + 3'd1);
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (rst) begin
      sel = 1'b0;
    end else if (halted) begin
      halt = 1'b1;
    end else begin
      case (state)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: rd = alu_op;
        // data_e leads wr by one phase so the bus is driven before the write strobe.
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: sel = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_veririsc_controller.sv
// Directed self-checking bench for veririsc_controller: each phase of each opcode
// is compared against hand-written strobe patterns.
module tb_veririsc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;

  int checks = 0;
  int passes = 0;
  int failures = 0;

  // Strobe bit order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  localparam logic [8:0] S  = 9'b1_0000_0000;
  localparam logic [8:0] R  = 9'b0_1000_0000;
  localparam logic [8:0] IR = 9'b0_0100_0000;
  localparam logic [8:0] IP = 9'b0_0010_0000;
  localparam logic [8:0] H  = 9'b0_0001_0000;
  localparam logic [8:0] LP = 9'b0_0000_1000;
  localparam logic [8:0] DE = 9'b0_0000_0100;
  localparam logic [8:0] LA = 9'b0_0000_0010;
  localparam logic [8:0] W  = 9'b0_0000_0001;
  localparam logic [8:0] Z  = 9'b0_0000_0000;

  veririsc_controller dut (
    .clk    (clk),
    .rst    (rst),
`ifdef VERIRISC_CTRL_STEP_EN
    .step   (1'b1),
`endif
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The bus driver and memory must never both drive the data bus.
  always @(negedge clk) begin
    checks++;
    assert (!(data_e && rd)) passes++;
    else begin
      failures++;
      $error("[TB] FAIL contention: observed data_e=%b rd=%b expected not both 1", data_e, rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] op, input logic z);
    rst    = r;
    opcode = op;
    zero   = z;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_phase, input logic [8:0] exp_ctrl);
    logic [11:0] observed;
    observed = {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    checks++;
    assert (observed === {exp_phase, exp_ctrl}) passes++;
    else begin
      failures++;
      $error("[TB] FAIL %s: observed phase=%0d ctrl=%b expected phase=%0d ctrl=%b",
             tag, observed[11:9], observed[8:0], exp_phase, exp_ctrl);
    end
  endtask

  // Starts in phase 0 just after an edge; walks phases 0..last_phase and, for a
  // full instruction, steps once more so the caller is back in phase 0.
  task automatic runInstr(input string name, input logic [2:0] op, input logic z,
                          input int last_phase, input logic [7:0][8:0] e);
    for (int p = 0; p <= last_phase; p++) begin
      if (p > 0) tick();
      applyStimulus(1'b0, op, z);
      checkOutput($sformatf("%s_p%0d", name, p), 3'(p), e[p]);
    end
    if (last_phase == 7) tick();
  endtask

  initial begin
    $display("[TB] veririsc_controller directed test start");

    applyStimulus(1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("reset_%0d", i), 3'd0, Z);
    end
    applyStimulus(1'b0, 3'd5, 1'b0);
    checkOutput("reset_release_p0", 3'd0, S);

    runInstr("lda", 3'd5, 1'b0, 7, {R|LA, R, R, IP, S|R|IR, S|R|IR, S|R, S});
    checkOutput("lda_wrap_p0", 3'd0, S);

    runInstr("add_z1", 3'd2, 1'b1, 7, {R|LA, R, R, IP, S|R|IR, S|R|IR, S|R, S});
    runInstr("sto", 3'd6, 1'b0, 7, {DE|W, DE, Z, IP, S|R|IR, S|R|IR, S|R, S});
    runInstr("skz_z1", 3'd1, 1'b1, 7, {Z, IP, Z, IP, S|R|IR, S|R|IR, S|R, S});
    runInstr("skz_z0", 3'd1, 1'b0, 7, {Z, Z, Z, IP, S|R|IR, S|R|IR, S|R, S});
    runInstr("jmp", 3'd7, 1'b0, 7, {LP, LP, Z, IP, S|R|IR, S|R|IR, S|R, S});

    runInstr("jmp_rst", 3'd7, 1'b0, 6, {Z, LP, Z, IP, S|R|IR, S|R|IR, S|R, S});
    applyStimulus(1'b1, 3'd7, 1'b0);
    tick();
    checkOutput("jmp_rst_after", 3'd0, Z);
    applyStimulus(1'b0, 3'd7, 1'b0);
    checkOutput("jmp_rst_release", 3'd0, S);

    runInstr("hlt", 3'd0, 1'b0, 4, {Z, Z, Z, IP|H, S|R|IR, S|R|IR, S|R, S});
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("halted_%0d", i), 3'd4, H);
    end
    applyStimulus(1'b1, 3'd0, 1'b0);
    checkOutput("halted_rst_comb", 3'd4, Z);
    tick();
    checkOutput("halted_rst_edge", 3'd0, Z);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("halted_rst_release", 3'd0, S);

    runInstr("hlt_rst", 3'd0, 1'b0, 4, {Z, Z, Z, IP|H, S|R|IR, S|R|IR, S|R, S});
    applyStimulus(1'b1, 3'd0, 1'b0);
    tick();
    checkOutput("hlt_rst_edge", 3'd0, Z);
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("hlt_rst_p0", 3'd0, S);
    tick();
    checkOutput("hlt_rst_p1", 3'd1, S|R);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/veririsc_controller.md
Name: veririsc_controller

Overview:
- Instruction sequencer for the VeriRISC CPU; sits directly upstream of the tri-state data bus driver and generates its enable (data_e) together with all other datapath strobes.
- Internal 3-bit phase counter steps through the 8-phase instruction cycle. Control outputs are decoded from the current phase, the IR opcode and the ALU zero flag.
- A halted state freezes the machine on HLT.

Parameters:
- PHASES, 8, number of phases per instruction cycle. Fixed at 8; any other value is unsupported and is flagged by an elaboration-time check.
- OPC_W, 3, opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  OPC_W  IR opcode field: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  input  1  accumulator-zero flag from ALU.
- sel  output  1  address mux select: 1=PC, 0=IR operand.
- rd  output  1  memory read strobe.
- ld_ir  output  1  instruction register load.
- inc_pc  output  1  PC increment.
- halt  output  1  CPU halted.
- ld_pc  output  1  PC load (jump).
- data_e  output  1  bus driver enable (drives accumulator onto data bus).
- ld_ac  output  1  accumulator load.
- wr  output  1  memory write strobe.
- phase  output  3  current phase, for debug/bench.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset state: phase=0, halted=0. While rst=1, every control output is 0, including sel, and phase=0.
- Phase register:
  - Advances 0→1→…→7→0, one step per clk.
  - Wraps from 7 to 0 with no gap cycle.
  - Does not advance while halted.
- Output decode:
  - Outputs are purely combinational from (phase, opcode, zero, halted); no extra latency.
  - An opcode change takes effect in the same cycle. opcode is only guaranteed stable from phase 3 onward.
  - Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Per-phase outputs (any output not listed is 0):
  - Phase 0 INST_ADDR: sel=1.
  - Phase 1 INST_FETCH: sel=1, rd=1.
  - Phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - Phase 3 IDLE: sel=1, rd=1, ld_ir=1.
  - Phase 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - Phase 5 OP_FETCH: rd=ALUOP.
  - Phase 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - Phase 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Bus contention rule: data_e and rd are never 1 in the same cycle. data_e rises one cycle before wr and falls with it.
- Halt:
  - HLT decoded in phase 4 sets halted on that clock edge.
  - From then on: phase stays 4, halt=1, all other outputs 0, including inc_pc. The PC increments exactly once for HLT, in the decode cycle.
  - Only rst clears halted.
- SKZ: zero is sampled combinationally in phase 6 only; zero in other phases is ignored.
- Reset mid-instruction: on the next edge, phase returns to 0 and outputs clear. No partial wr or data_e persists past the reset edge.
- Simultaneous rst and HLT decode: rst wins; halted=0.

Optional Feature:
- Macro: VERIRISC_CTRL_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - Phase advances only on edges where step=1. When step=0, phase holds and the outputs for the current phase are held, so strobes stay asserted across stall cycles.
  - rst and halt behaviour are unchanged.
- Undefined: no step port; phase advances every cycle.

Test Plan:
- Reset: hold rst=1 for 3 clks with opcode=STO → all outputs 0, phase=0. Release rst → sel=1 in phase 0, rd=1 in phase 1.
- LDA (opcode=5), zero=0, one full cycle → rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; data_e=0 and wr=0 throughout; phase wraps 7→0.
- STO (opcode=6) → data_e=1 in phases 6 and 7, wr=1 only in phase 7, rd=0 in phases 5–7. Assert !(data_e && rd) every cycle.
- SKZ (opcode=1) run twice, zero=1 then zero=0 → inc_pc=1 in phase 6 only when zero=1; inc_pc=1 in phase 4 both times.
- HLT (opcode=0) → in phase 4, halt=1 and inc_pc=1 for one cycle. For the next 10 clks phase=4, halt=1, inc_pc=0. Then rst=1 → phase=0, halt=0.
- JMP (opcode=7) with rst asserted in phase 6 → ld_pc=1 in phase 6; on the next cycle phase=0, ld_pc=0, and no phase-7 strobes appear.
